// File: rtl/calc_pkg.sv
// Shared calculator types and sizing: result width, display digit count,
// converter FSM states and the BCD digit type used by the segment decoders.
package calc_pkg;

    localparam int CALC_W      = 16;
    localparam int CALC_DIGITS = 5;

    typedef enum logic {
        IDLE,
        SHIFT
    } b2b_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
module bcd_add3
    import calc_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // Values 5..9 map to 8..12 and stay within four bits; 10..15 never occur.
    assign digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/calc_bin2bcd.sv
// Sequential binary-to-BCD converter for the calculator display path.
// One double-dabble iteration per clock; results and the leading-zero blank
// mask are only updated on completion, so the displays never see partial sums.
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int W      = CALC_W,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int RW = BW + W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0]     LAST_CNT    = CW'(W - 1);
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS - 1){1'b1}}, 1'b0};

    b2b_state_t        state_q, state_d;
    logic [RW-1:0]     work_q,  work_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [BW-1:0]     bcd_q,   bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              done_q,  done_d;

    logic [BW-1:0]     corrected;
    logic [RW-1:0]     shifted;
    logic [DIGITS-1:0] new_blank;
    logic              zero_run;

    // Add-3 correction on every digit of the working BCD field, before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[W + 4*g +: 4]),
            .digit_o (corrected[4*g +: 4])
        );
    end

    assign shifted = {corrected, work_q[W-1:0]} << 1;

    // Leading-zero mask from the post-shift digits: digit i is blank when it
    // and every more significant digit are zero; the units digit always shows.
    always_comb begin
        new_blank = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (shifted[W + 4*i +: 4] == 4'd0);
            new_blank[i] = zero_run;
        end
    end

    // Next-state logic: accept a request in IDLE, iterate in SHIFT, publish on the last shift.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {{BW{1'b0}}, bin};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = shifted[RW-1:W];
                    blank_d = new_blank;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RESET;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            done_q  <= done_d;
        end
    end

    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;

endmodule
